// File: rtl/nram_mux_mp.sv
// Small register-array RAM with one write port, two 1-cycle-latency read ports and a sequenced clear.
// Optional macro NRAM_BYPASS_EN: same-cycle write->read forwarding on matching addresses.
module nram_mux_mp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  io_WE,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] io_WADD,
    input  logic [WIDTH-1:0]                      io_D,
    input  logic                                  io_RE0,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] io_RADD0,
    output logic [WIDTH-1:0]                      io_Q0,
    output logic                                  io_QV0,
    input  logic                                  io_RE1,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] io_RADD1,
    output logic [WIDTH-1:0]                      io_Q1,
    output logic                                  io_QV1,
    input  logic                                  io_CLR,
    output logic                                  io_BUSY
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wadd_ok, radd0_ok, radd1_ok;
    logic             wr_acc;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] rd0_data, rd1_data;

    assign wadd_ok  = {1'b0, io_WADD}  < DEPTH_W;
    assign radd0_ok = {1'b0, io_RADD0} < DEPTH_W;
    assign radd1_ok = {1'b0, io_RADD1} < DEPTH_W;

    // A clear request in IDLE wins over a simultaneous write.
    assign wr_acc   = (state == IDLE) && io_WE && !io_CLR && wadd_ok;

    assign mem_we   = wr_acc || (state == CLEAR);
    assign mem_addr = (state == CLEAR) ? cnt : io_WADD;
    assign mem_data = (state == CLEAR) ? '0 : io_D;

    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        if (radd0_ok) rd0_data = mem[io_RADD0];
        if (radd1_ok) rd1_data = mem[io_RADD1];
`ifdef NRAM_BYPASS_EN
        if (wr_acc && (io_WADD == io_RADD0)) rd0_data = io_D;
        if (wr_acc && (io_WADD == io_RADD1)) rd1_data = io_D;
`endif
    end

    // Array storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            io_Q0   <= '0;
            io_Q1   <= '0;
            io_QV0  <= 1'b0;
            io_QV1  <= 1'b0;
            io_BUSY <= 1'b0;
        end else begin
            io_QV0 <= 1'b0;
            io_QV1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_RE0) begin
                        io_QV0 <= 1'b1;
                        io_Q0  <= rd0_data;
                    end
                    if (io_RE1) begin
                        io_QV1 <= 1'b1;
                        io_Q1  <= rd1_data;
                    end
                    if (io_CLR) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        io_BUSY <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        io_BUSY <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    io_BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule
